// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile_wb register file.
// Build option: REGFILE_BYPASS_EN enables staged-write forwarding on the read ports.
package regfile_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef reg_data_t [NREGS-1:0] reg_array_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wb_stage_t;
endpackage

// File: rtl/regfile_if.sv
// Write-back and read-port bundle for regfile_wb.
// Build option: REGFILE_BYPASS_EN (affects read data timing only).
interface regfile_if;
    import regfile_pkg::*;

    // Write request: no handshake; wr_en is sampled every rising edge and the
    // file always accepts, so there is no ready. flush kills the staged slot.
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    logic      flush;
    reg_addr_t rd_addr_a;
    reg_addr_t rd_addr_b;
    reg_data_t rd_data_a;
    reg_data_t rd_data_b;
    logic      wb_pending;

    modport master (
        output wr_en, wr_addr, wr_data, flush, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_pending
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, flush, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_pending
    );
endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: array mux plus optional staged-write bypass.
// Build option: REGFILE_BYPASS_EN forwards a matching staged write.
module regfile_rd_port
    import regfile_pkg::*;
(
    input  reg_array_t regs,
    input  wb_stage_t  stage,
    input  reg_addr_t  rd_addr,
    output reg_data_t  rd_data
);

`ifdef REGFILE_BYPASS_EN
    assign rd_data = (stage.valid && (stage.addr == rd_addr)) ? stage.data : regs[rd_addr];
`else
    // Without forwarding the stage is invisible to readers.
    logic unused_stage;
    assign unused_stage = ^stage;
    assign rd_data      = regs[rd_addr];
`endif

endmodule

// File: rtl/regfile_wb.sv
// 8x8 register file behind a one-stage write-back register; writes land one edge after capture.
// Build option: REGFILE_BYPASS_EN makes staged writes readable immediately.
module regfile_wb
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    regfile_if.slave  bus
);

    reg_array_t array_q, array_d;
    wb_stage_t  stage_q, stage_d;
    reg_data_t  rd_a, rd_b;

    always_comb begin
        array_d = array_q;
        stage_d = stage_q;
        // Commit uses the pre-edge stage; a flush on the same edge suppresses it.
        if (stage_q.valid && !bus.flush) begin
            array_d[stage_q.addr] = stage_q.data;
        end
        if (bus.flush) begin
            stage_d.valid = 1'b0;
        end else begin
            stage_d.valid = bus.wr_en;
            if (bus.wr_en) begin
                stage_d.addr = bus.wr_addr;
                stage_d.data = bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            array_q <= '0;
            stage_q <= '0;
        end else begin
            array_q <= array_d;
            stage_q <= stage_d;
        end
    end

    regfile_rd_port u_rd_a (
        .regs    (array_q),
        .stage   (stage_q),
        .rd_addr (bus.rd_addr_a),
        .rd_data (rd_a)
    );

    regfile_rd_port u_rd_b (
        .regs    (array_q),
        .stage   (stage_q),
        .rd_addr (bus.rd_addr_b),
        .rd_data (rd_b)
    );

    assign bus.rd_data_a  = rd_a;
    assign bus.rd_data_b  = rd_b;
    assign bus.wb_pending = stage_q.valid;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: driver pushes expected {wb_pending, rd_a, rd_b}, monitor compares at negedge.
// Build option: REGFILE_BYPASS_EN selects the forwarding expectation.
module tb_regfile_wb;
    logic clk;
    logic reset;

    regfile_if bus ();

    regfile_wb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] mem [8];
    logic       pend_v;
    logic [2:0] pend_a;
    logic [7:0] pend_d;

    function automatic logic [7:0] model_read(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        if (pend_v && pend_a == a) return pend_d;
`endif
        return mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        pend_v = 1'b0;
        pend_a = 3'd0;
        pend_d = 8'h00;
    endtask

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];
    string       tag_q[$];
    int          checks   = 0;
    int          failures = 0;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [16:0] e;
            logic [16:0] got;
            string       t;
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = {bus.wb_pending, bus.rd_data_a, bus.rd_data_b};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s: got pend=%b a=%h b=%h, expected pend=%b a=%h b=%h",
                         t, got[16], got[15:8], got[7:0], e[16], e[15:8], e[7:0]);
            end
        end
    end

    task automatic push_exp(input string t);
        exp_q.push_back({pend_v, model_read(bus.rd_addr_a), model_read(bus.rd_addr_b)});
        tag_q.push_back(t);
    endtask

    // ---------------- driver ----------------
    // Drive one cycle's inputs, queue the expected outputs, then advance the model across the edge.
    task automatic cycle(input string t, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic fl, input logic [2:0] ra, input logic [2:0] rb);
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.flush     = fl;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        push_exp(t);
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (pend_v && !fl) mem[pend_a] = pend_d;
            if (fl) begin
                pend_v = 1'b0;
            end else begin
                pend_v = we;
                if (we) begin
                    pend_a = wa;
                    pend_d = wd;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input string t, input logic [2:0] ra, input logic [2:0] rb);
        cycle(t, 1'b0, 3'd0, 8'h00, 1'b0, ra, rb);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        model_clear();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.flush = 1'b0;
        bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        repeat (2) @(posedge clk);
        #1;
        idle("reset_state", 3'd0, 3'd7);
        reset = 1'b0;

        // Async reset with a write still staged: read must drop to 0 without a clock edge.
        cycle("rst_w_r3", 1'b1, 3'd3, 8'hA5, 1'b0, 3'd3, 3'd3);
        reset = 1'b1;
        model_clear();
        #1;
        idle("rst_async", 3'd3, 3'd3);
        reset = 1'b0;
        repeat (3) idle("rst_no_commit", 3'd3, 3'd3);

        // Single write latency.
        cycle("lat_w_r2", 1'b1, 3'd2, 8'h3C, 1'b0, 3'd2, 3'd0);
        idle("lat_edge1", 3'd2, 3'd2);
        idle("lat_edge2", 3'd2, 3'd2);

        // Back-to-back writes to the same register.
        cycle("b2b_w1", 1'b1, 3'd5, 8'h11, 1'b0, 3'd0, 3'd5);
        cycle("b2b_w2", 1'b1, 3'd5, 8'h22, 1'b0, 3'd0, 3'd5);
        idle("b2b_e2", 3'd5, 3'd5);
        idle("b2b_e3", 3'd5, 3'd5);

        // Committed write survives a later flush; the flushed write is discarded.
        cycle("fl_w_r1", 1'b1, 3'd1, 8'h7F, 1'b0, 3'd1, 3'd4);
        idle("fl_commit_r1", 3'd1, 3'd4);
        cycle("fl_w_r4", 1'b1, 3'd4, 8'h99, 1'b1, 3'd1, 3'd4);
        idle("fl_after1", 3'd1, 3'd4);
        idle("fl_after2", 3'd1, 3'd4);

        // Flush kills a staged write before it commits.
        cycle("fl_w_r6", 1'b1, 3'd6, 8'h55, 1'b0, 3'd6, 3'd6);
        cycle("fl_kill_r6", 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd6);
        idle("fl_r6_after1", 3'd6, 3'd6);
        idle("fl_r6_after2", 3'd6, 3'd6);

        // Fill every register, read back on both ports.
        for (int i = 0; i < 8; i++)
            cycle("fill_w", 1'b1, 3'(i), 8'h10 + 8'(i), 1'b0, 3'(i), 3'(i));
        for (int j = 0; j < 8; j++) idle("fill_same", 3'(j), 3'(j));
        for (int j = 0; j < 8; j++) idle("fill_cross", 3'(j), 3'(7 - j));

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cycle("rand",
                  1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 7) == 0),
                  3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
        end
        for (int j = 0; j < 8; j++) idle("final_dump", 3'(j), 3'(7 - j));

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
